// File: rtl/ahb_mtx_pkg.sv
// ahb_mtx_pkg: shared AHB-Lite encodings and payload types for the bus-matrix
// output stage and its round-robin arbiter.
package ahb_mtx_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_e;

    // Address-phase control payload of one input stage (address carried separately
    // because its width is a per-instance parameter).
    typedef struct packed {
        logic [1:0] trans;
        logic       write;
        logic [2:0] size;
        logic [2:0] burst;
        logic [3:0] prot;
        logic       mastlock;
    } ahb_ctrl_t;

    // SEQ and BUSY both continue a burst already under way.
    function automatic logic trans_continues(input logic [1:0] trans);
        return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/ahb_mtx_arb.sv
// ahb_mtx_arb: two-port round-robin arbiter with hold/lock qualifier.
// Ports:
//   HCLK, HRESETn  clock, async active-low reset
//   req[1:0]       per-port transfer request
//   hold           current owner keeps the grant (burst continuation or lock)
//   HREADYOUTM     slave ready; arbitration only takes effect when high
//   addr_owner     registered address-phase owner
//   no_port        registered "no owner" flag
//   last_grant     registered port that won the last fresh grant
//   addr_owner_c   owner for this cycle (zero latency)
//   no_port_c      "no owner" for this cycle, forced during reset
module ahb_mtx_arb
    import ahb_mtx_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [1:0] req,
    input  logic       hold,
    input  logic       HREADYOUTM,
    output logic       addr_owner,
    output logic       no_port,
    output logic       last_grant,
    output logic       addr_owner_c,
    output logic       no_port_c
);

    logic grant_owner;
    logic grant_none;
    logic grant_new;

    // Candidate grant for this cycle.
    always_comb begin
        grant_owner = addr_owner;
        grant_none  = 1'b1;
        grant_new   = 1'b0;
        if (hold) begin
            grant_none = 1'b0;
        end else begin
            case (req)
                2'b11: begin
                    grant_owner = ~last_grant;
                    grant_none  = 1'b0;
                    grant_new   = 1'b1;
                end
                2'b01: begin
                    grant_owner = 1'b0;
                    grant_none  = 1'b0;
                    grant_new   = 1'b1;
                end
                2'b10: begin
                    grant_owner = 1'b1;
                    grant_none  = 1'b0;
                    grant_new   = 1'b1;
                end
                default: begin
                    // No request: park on the previous owner with no_port set.
                    grant_owner = addr_owner;
                    grant_none  = 1'b1;
                end
            endcase
        end
    end

    // While the slave stalls the previous decision stays on the bus.
    assign addr_owner_c = HREADYOUTM ? grant_owner : addr_owner;
    assign no_port_c    = !HRESETn || (HREADYOUTM ? grant_none : no_port);

    // Arbitration state, frozen across wait states.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_owner <= 1'b0;
            no_port    <= 1'b1;
            last_grant <= 1'b1;
        end else if (HREADYOUTM) begin
            addr_owner <= grant_owner;
            no_port    <= grant_none;
            if (grant_new) begin
                last_grant <= grant_owner;
            end
        end
    end

endmodule

// File: rtl/ahb_mtx_output_stage.sv
// ahb_mtx_output_stage: slave-facing end of the bus matrix. Arbitrates two input
// stages onto one AHB-Lite master interface and steers write data by the
// registered data-phase owner.
// Ports:
//   HCLK, HRESETn           clock, async active-low reset
//   *_op0 / *_op1           request, address and control from SI0 / SI1
//   active_op0/1            port owns the address phase this cycle
//   HSELM..HMASTLOCKM       muxed address phase to the slave
//   HWDATAM                 write data of the current data-phase owner
//   HREADYOUTM / HREADYMUXM slave ready in / ready fed back to the slave
module ahb_mtx_output_stage
    import ahb_mtx_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              sel_op0,
    input  logic              sel_op1,
    input  logic              held_tran_op0,
    input  logic              held_tran_op1,
    input  logic [ADDR_W-1:0] addr_op0,
    input  logic [ADDR_W-1:0] addr_op1,
    input  logic [1:0]        trans_op0,
    input  logic [1:0]        trans_op1,
    input  logic              write_op0,
    input  logic              write_op1,
    input  logic [2:0]        size_op0,
    input  logic [2:0]        size_op1,
    input  logic [2:0]        burst_op0,
    input  logic [2:0]        burst_op1,
    input  logic [3:0]        prot_op0,
    input  logic [3:0]        prot_op1,
    input  logic              mastlock_op0,
    input  logic              mastlock_op1,
    input  logic [DATA_W-1:0] wdata_op0,
    input  logic [DATA_W-1:0] wdata_op1,
    output logic              active_op0,
    output logic              active_op1,
    output logic              HSELM,
    output logic [ADDR_W-1:0] HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [3:0]        HPROTM,
    output logic              HMASTLOCKM,
    output logic [DATA_W-1:0] HWDATAM,
    input  logic              HREADYOUTM,
    output logic              HREADYMUXM
);

    ahb_ctrl_t  ctrl_v [2];
    ahb_ctrl_t  ctrl_q;
    ahb_ctrl_t  ctrl_a;
    logic [1:0] req;
    logic       hold;
    logic       addr_owner_q;
    logic       no_port_q;
    logic       last_grant;
    logic       addr_owner_c;
    logic       no_port_c;
    logic       sel_a;
    logic       data_owner;
    logic       data_valid;

    assign ctrl_v[0] = {trans_op0, write_op0, size_op0, burst_op0, prot_op0, mastlock_op0};
    assign ctrl_v[1] = {trans_op1, write_op1, size_op1, burst_op1, prot_op1, mastlock_op1};

    assign req = {sel_op1 & held_tran_op1, sel_op0 & held_tran_op0};

    // Hold is judged on what the registered owner presents now; sel is ignored so
    // a protocol-violating owner still cannot lose a burst mid-way.
    assign ctrl_q = ctrl_v[addr_owner_q];
    assign hold   = !no_port_q &&
                    (trans_continues(ctrl_q.trans) ||
                     ctrl_q.mastlock ||
                     ((ctrl_q.trans == HTRANS_NONSEQ) &&
                      (ctrl_q.burst != HBURST_SINGLE) && !HREADYOUTM));

    ahb_mtx_arb u_arb (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req          (req),
        .hold         (hold),
        .HREADYOUTM   (HREADYOUTM),
        .addr_owner   (addr_owner_q),
        .no_port      (no_port_q),
        .last_grant   (last_grant),
        .addr_owner_c (addr_owner_c),
        .no_port_c    (no_port_c)
    );

    // Address-phase mux; a parked owner still drives address/control, but
    // select, transfer type and lock are suppressed.
    assign ctrl_a     = ctrl_v[addr_owner_c];
    assign sel_a      = addr_owner_c ? sel_op1 : sel_op0;
    assign HSELM      = !no_port_c && sel_a;
    assign HTRANSM    = HSELM ? ctrl_a.trans : HTRANS_IDLE;
    assign HMASTLOCKM = !no_port_c && ctrl_a.mastlock;
    assign HADDRM     = addr_owner_c ? addr_op1 : addr_op0;
    assign HWRITEM    = ctrl_a.write;
    assign HSIZEM     = ctrl_a.size;
    assign HBURSTM    = ctrl_a.burst;
    assign HPROTM     = ctrl_a.prot;

    assign active_op0 = !no_port_c && !addr_owner_c && sel_op0;
    assign active_op1 = !no_port_c &&  addr_owner_c && sel_op1;

    assign HREADYMUXM = HREADYOUTM;

    // Data-phase owner advances with each accepted address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_owner <= 1'b0;
            data_valid <= 1'b0;
        end else if (HREADYOUTM) begin
            data_owner <= addr_owner_c;
            data_valid <= HSELM & HTRANSM[1];
        end
    end

    assign HWDATAM = data_owner ? wdata_op1 : wdata_op0;

    // A real data phase is only ever launched by a port that held the address phase.
    a_valid_has_owner: assert property (@(posedge HCLK) disable iff (!HRESETn)
        data_valid |-> !no_port_q);

    // Whenever a port owns the bus it was the winner of the latest fresh grant.
    a_owner_is_last_grant: assert property (@(posedge HCLK) disable iff (!HRESETn)
        !no_port_q |-> (last_grant == addr_owner_q));

endmodule

// File: tb/tb_ahb_mtx_output_stage.sv
// tb_ahb_mtx_output_stage: directed scenarios plus randomized traffic, each
// cycle compared against a behavioural model of the output stage.
module tb_ahb_mtx_output_stage;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        sel   [2];
    logic        held  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [1:0]  trans [2];
    logic        wr    [2];
    logic        lk    [2];
    logic [2:0]  sz    [2];
    logic [2:0]  bst   [2];
    logic [3:0]  prt   [2];
    logic        rdy;

    logic        active_op0, active_op1, HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
    logic [31:0] HADDRM, HWDATAM;
    logic [1:0]  HTRANSM;
    logic [2:0]  HSIZEM, HBURSTM;
    logic [3:0]  HPROTM;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: who owns the address phase, whether anyone does, last fresh
    // grant, and whose write data is in the data phase.
    int m_owner, m_last, m_downer;
    bit m_none;
    int g;
    bit gn, gnew;

    always #5 HCLK = ~HCLK;

    ahb_mtx_output_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .sel_op0       (sel[0]),
        .sel_op1       (sel[1]),
        .held_tran_op0 (held[0]),
        .held_tran_op1 (held[1]),
        .addr_op0      (addr[0]),
        .addr_op1      (addr[1]),
        .trans_op0     (trans[0]),
        .trans_op1     (trans[1]),
        .write_op0     (wr[0]),
        .write_op1     (wr[1]),
        .size_op0      (sz[0]),
        .size_op1      (sz[1]),
        .burst_op0     (bst[0]),
        .burst_op1     (bst[1]),
        .prot_op0      (prt[0]),
        .prot_op1      (prt[1]),
        .mastlock_op0  (lk[0]),
        .mastlock_op1  (lk[1]),
        .wdata_op0     (wdata[0]),
        .wdata_op1     (wdata[1]),
        .active_op0    (active_op0),
        .active_op1    (active_op1),
        .HSELM         (HSELM),
        .HADDRM        (HADDRM),
        .HTRANSM       (HTRANSM),
        .HWRITEM       (HWRITEM),
        .HSIZEM        (HSIZEM),
        .HBURSTM       (HBURSTM),
        .HPROTM        (HPROTM),
        .HMASTLOCKM    (HMASTLOCKM),
        .HWDATAM       (HWDATAM),
        .HREADYOUTM    (rdy),
        .HREADYMUXM    (HREADYMUXM)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_none   = 1'b1;
        m_last   = 1;
        m_downer = 0;
    endtask

    // Decide this cycle's owner from the rules, then compare every output at the
    // falling edge.
    task automatic eval_check();
        bit keep, r0, r1;
        logic        e_sel, e_act0, e_act1, e_lock;
        logic [1:0]  e_trans;
        logic [31:0] e_wdata;
        gnew = 1'b0;
        if (!HRESETn) begin
            g  = 0;
            gn = 1'b1;
        end else begin
            keep = !m_none && (trans[m_owner] == 2'b01 || trans[m_owner] == 2'b11 || lk[m_owner]);
            r0   = sel[0] && held[0];
            r1   = sel[1] && held[1];
            if (!rdy) begin
                g  = m_owner;
                gn = m_none;
            end else if (keep) begin
                g  = m_owner;
                gn = 1'b0;
            end else if (r0 && r1) begin
                g = 1 - m_last; gn = 1'b0; gnew = 1'b1;
            end else if (r0) begin
                g = 0; gn = 1'b0; gnew = 1'b1;
            end else if (r1) begin
                g = 1; gn = 1'b0; gnew = 1'b1;
            end else begin
                g  = m_owner;
                gn = 1'b1;
            end
        end
        e_sel   = !gn && sel[g];
        e_trans = e_sel ? trans[g] : 2'b00;
        e_act0  = !gn && (g == 0) && sel[0];
        e_act1  = !gn && (g == 1) && sel[1];
        e_lock  = !gn && lk[g];
        e_wdata = HRESETn ? wdata[m_downer] : wdata[0];
        @(negedge HCLK);
        chk("hselm",      HSELM,      e_sel);
        chk("htransm",    HTRANSM,    e_trans);
        chk("active0",    active_op0, e_act0);
        chk("active1",    active_op1, e_act1);
        chk("act_both",   active_op0 & active_op1, 1'b0);
        chk("hmastlockm", HMASTLOCKM, e_lock);
        chk("hwdatam",    HWDATAM,    e_wdata);
        chk("hreadymux",  HREADYMUXM, rdy);
        if (HRESETn) begin
            chk("haddrm",  HADDRM,  addr[g]);
            chk("hwritem", HWRITEM, wr[g]);
            chk("hsizem",  HSIZEM,  sz[g]);
            chk("hburstm", HBURSTM, bst[g]);
            chk("hprotm",  HPROTM,  prt[g]);
        end
    endtask

    // Clock edge: the model commits the cycle's decision alongside the DUT.
    task automatic adv();
        @(posedge HCLK);
        if (!HRESETn) begin
            model_reset();
        end else if (rdy) begin
            m_owner  = g;
            m_none   = gn;
            if (gnew) m_last = g;
            m_downer = g;
        end
        #1;
    endtask

    task automatic set_port(input int p, input logic s, input logic [1:0] t,
                            input logic [2:0] b, input logic l);
        sel[p]   = s;
        trans[p] = t;
        held[p]  = t[1];
        bst[p]   = b;
        lk[p]    = l;
        addr[p]  = $urandom;
        wdata[p] = $urandom;
        wr[p]    = 1'($urandom);
        sz[p]    = 3'($urandom);
        prt[p]   = 4'($urandom);
    endtask

    task automatic idle_all();
        set_port(0, 1'b0, 2'b00, 3'd0, 1'b0);
        set_port(1, 1'b0, 2'b00, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        rdy     = 1'b1;
        idle_all();
        eval_check();
        adv();
        HRESETn = 1'b1;
    endtask

    logic [1:0] burst_tr [5];

    initial begin
        HRESETn = 1'b0;
        rdy     = 1'b1;
        idle_all();
        model_reset();
        @(posedge HCLK);
        #1;

        // Single SI0 write.
        do_reset();
        idle_all();
        set_port(0, 1'b1, 2'b10, 3'd0, 1'b0);
        addr[0] = 32'h0000_0100;
        wr[0]   = 1'b1;
        wdata[0] = 32'hDEAD_BEEF;
        eval_check();
        chk("single_act0",  active_op0, 1'b1);
        chk("single_haddr", HADDRM, 32'h0000_0100);
        chk("single_trans", HTRANSM, 2'b10);
        adv();
        idle_all();
        wdata[0] = 32'hDEAD_BEEF;
        eval_check();
        chk("single_wdata", HWDATAM, 32'hDEAD_BEEF);
        adv();

        // Both ports issue SINGLE transfers back to back.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1'b1, 2'b10, 3'd0, 1'b0);
            set_port(1, 1'b1, 2'b10, 3'd0, 1'b0);
            eval_check();
            chk("rr_act0", active_op0, 1'(i % 2 == 0));
            chk("rr_act1", active_op1, 1'(i % 2 == 1));
            adv();
        end

        // SI1 INCR4 burst with a BUSY beat while SI0 waits.
        do_reset();
        burst_tr[0] = 2'b10; burst_tr[1] = 2'b11; burst_tr[2] = 2'b01;
        burst_tr[3] = 2'b11; burst_tr[4] = 2'b11;
        for (int b = 0; b < 5; b++) begin
            set_port(1, 1'b1, burst_tr[b], 3'd3, 1'b0);
            if (b == 0) set_port(0, 1'b0, 2'b00, 3'd0, 1'b0);
            else        set_port(0, 1'b1, 2'b10, 3'd0, 1'b0);
            eval_check();
            chk("burst_hold", active_op1, 1'b1);
            adv();
        end
        set_port(1, 1'b1, 2'b00, 3'd0, 1'b0);
        set_port(0, 1'b1, 2'b10, 3'd0, 1'b0);
        eval_check();
        chk("burst_release", active_op0, 1'b1);
        adv();

        // Locked SI0 sequence with an IDLE gap; SI1 requests throughout.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            set_port(0, 1'b1, (b == 1) ? 2'b00 : 2'b10, 3'd0, 1'(b != 3));
            set_port(1, 1'b1, 2'b10, 3'd0, 1'b0);
            eval_check();
            chk("lock_act1", active_op1, 1'(b == 3));
            adv();
        end

        // Wait states during an SI0 transfer.
        do_reset();
        idle_all();
        set_port(0, 1'b1, 2'b10, 3'd0, 1'b0);
        eval_check();
        adv();
        for (int w = 0; w < 4; w++) begin
            rdy = (w == 3);
            set_port(0, 1'b1, 2'b00, 3'd0, 1'b0);
            set_port(1, 1'b1, 2'b10, 3'd0, 1'b0);
            eval_check();
            chk("wait_act1", active_op1, 1'(w == 3));
            if (w < 3) chk("wait_wdata", HWDATAM, wdata[0]);
            adv();
        end
        rdy = 1'b1;

        // Reset in the middle of an SI1 burst.
        do_reset();
        idle_all();
        set_port(1, 1'b1, 2'b10, 3'd3, 1'b0);
        eval_check();
        adv();
        set_port(1, 1'b1, 2'b11, 3'd3, 1'b0);
        eval_check();
        adv();
        set_port(1, 1'b1, 2'b11, 3'd3, 1'b0);
        HRESETn = 1'b0;
        eval_check();
        chk("rst_hsel",  HSELM, 1'b0);
        chk("rst_trans", HTRANSM, 2'b00);
        chk("rst_act",   {active_op1, active_op0}, 2'b00);
        adv();
        HRESETn = 1'b1;
        set_port(0, 1'b1, 2'b10, 3'd0, 1'b0);
        set_port(1, 1'b1, 2'b10, 3'd0, 1'b0);
        eval_check();
        chk("rst_first", active_op0, 1'b1);
        adv();

        // Randomized traffic with wait states and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rdy     = ($urandom % 4) != 0;
            HRESETn = ($urandom % 250) != 0;
            for (int p = 0; p < 2; p++) begin
                set_port(p, 1'(($urandom % 8) != 0), 2'($urandom), 3'($urandom),
                         1'(($urandom % 6) == 0));
                held[p] = trans[p][1] ? 1'(($urandom % 8) != 0) : 1'(($urandom % 4) == 0);
            end
            eval_check();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
